// File: rtl/key_scan_mod.sv
// 4x4 matrix-keypad scanner: walks the columns active-low, synchronizes the rows,
// debounces whole-matrix frames and reports new presses as a pulse plus key code.
module key_scan_mod #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  Row_In,
  output logic [3:0]  Column_Scan_Sig,
  output logic [3:0]  Key_Code,
  output logic        Key_Valid,
  output logic        Key_Down,
  output logic [15:0] Key_Map
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEB_SCANS - 1);

  logic [3:0]    row_meta_reg;
  logic [3:0]    row_sync_reg;
  logic [3:0]    row_act;
  logic [DW-1:0] dwell_cnt_reg;
  logic [1:0]    col_idx_reg;
  logic [1:0]    col_idx_next;
  logic [3:0]    col_drive_reg;
  logic          dwell_end;
  logic [3:0]    frame_col_reg [4];
  logic [15:0]   frame_cur;
  logic          frame_done_reg;
  logic [15:0]   last_frame_reg;
  logic [MW-1:0] match_cnt_reg;
  logic [MW-1:0] match_cnt_next;
  logic          frame_same;
  logic          frame_accept;
  logic [15:0]   new_bits;
  logic [3:0]    new_code;
  logic [15:0]   key_map_reg;
  logic          key_down_reg;
  logic [3:0]    key_code_reg;
  logic          key_valid_reg;

  // Rows idle high, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= Row_In;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign row_act      = ~row_sync_reg;
  assign dwell_end    = (dwell_cnt_reg == DWELL_LAST);
  assign col_idx_next = col_idx_reg + 2'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell_cnt_reg <= '0;
      col_idx_reg   <= 2'd0;
      col_drive_reg <= 4'b1110;
    end else if (dwell_end) begin
      dwell_cnt_reg <= '0;
      col_idx_reg   <= col_idx_next;
      col_drive_reg <= ~(4'b0001 << col_idx_next);
    end else begin
      dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
    end
  end

  // Each column's rows are captured at the very end of its dwell, long after settling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_frame_col
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          frame_col_reg[gi] <= 4'h0;
        end else if (dwell_end && (col_idx_reg == 2'(gi))) begin
          frame_col_reg[gi] <= row_act;
        end
      end
    end
  endgenerate

  assign frame_cur = {frame_col_reg[3], frame_col_reg[2], frame_col_reg[1], frame_col_reg[0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= dwell_end && (col_idx_reg == 2'd3);
    end
  end

  always_comb begin
    frame_same     = (frame_cur == last_frame_reg);
    match_cnt_next = '0;
    if (frame_same) begin
      match_cnt_next = (match_cnt_reg == MATCH_LAST) ? MATCH_LAST : match_cnt_reg + 1'b1;
    end
    frame_accept = frame_done_reg && frame_same && (match_cnt_next == MATCH_LAST);
    new_bits     = frame_cur & ~key_map_reg;
  end

  // Lowest-index new key wins when several appear in one accepted frame.
  always_comb begin
    new_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_bits[i]) begin
        new_code = 4'(i);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_frame_reg <= 16'h0000;
      match_cnt_reg  <= '0;
      key_map_reg    <= 16'h0000;
      key_down_reg   <= 1'b0;
      key_code_reg   <= 4'd0;
      key_valid_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      if (frame_done_reg) begin
        match_cnt_reg <= match_cnt_next;
        if (!frame_same) begin
          last_frame_reg <= frame_cur;
        end
        if (frame_accept && (frame_cur != key_map_reg)) begin
          key_map_reg  <= frame_cur;
          key_down_reg <= |frame_cur;
          if (|new_bits) begin
            key_code_reg  <= new_code;
            key_valid_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign Column_Scan_Sig = col_drive_reg;
  assign Key_Code        = key_code_reg;
  assign Key_Valid       = key_valid_reg;
  assign Key_Down        = key_down_reg;
  assign Key_Map         = key_map_reg;

endmodule

// File: tb/tb_key_scan_mod.sv
// Bench for key_scan_mod: a keypad model drives the rows from the column drive,
// a table of held-key steps sets stimulus, and a queue scoreboards Key_Valid pulses.
module tb_key_scan_mod;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  Row_In;
  logic [3:0]  Column_Scan_Sig;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Down;
  logic [15:0] Key_Map;

  key_scan_mod #(.SCAN_DIV(4), .DEB_SCANS(3)) dut (
    .CLK(CLK), .RST(RST), .Row_In(Row_In), .Column_Scan_Sig(Column_Scan_Sig),
    .Key_Code(Key_Code), .Key_Valid(Key_Valid), .Key_Down(Key_Down), .Key_Map(Key_Map)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulse_off;
    logic [3:0]  exp_code;
    logic [15:0] exp_map;
    logic        exp_down;
  } step_t;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] map;
    int          cyc;
  } sb_t;

  sb_t         sb_q[$];
  step_t       steps[8];
  step_t       pend;
  logic        pend_valid = 1'b0;
  logic [15:0] keys = 16'h0000;
  int          cyc = 0;
  int          fidx = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    Row_In = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[c*4+r] && !Column_Scan_Sig[c]) Row_In[r] = 1'b0;
      end
    end
  end

  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0] one_hot;
    sb_t        e;
    if (!RST) begin
      one_hot = 4'b0001 << ((cyc / 4) % 4);
      check("column_scan", {28'h0, Column_Scan_Sig}, {28'h0, ~one_hot});
      if (Key_Valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got Key_Valid=1 code %0d, expected no pulse (cycle %0d)", Key_Code, cyc);
        end else begin
          e = sb_q.pop_front();
          check("pulse_code", {28'h0, Key_Code}, {28'h0, e.code});
          check("pulse_map", {16'h0, Key_Map}, {16'h0, e.map});
          check("pulse_cycle", cyc, e.cyc);
          $display("pulse: cycle %0d code %0d map %04h", cyc, Key_Code, Key_Map);
        end
      end
    end
  end

  task automatic step_check();
    check("step_map", {16'h0, Key_Map}, {16'h0, pend.exp_map});
    check("step_code", {28'h0, Key_Code}, {28'h0, pend.exp_code});
    check("step_down", {31'h0, Key_Down}, {31'h0, pend.exp_down});
    check("pulse_missing", sb_q.size(), 0);
    $display("step: keys %04h -> map %04h code %0d down %0b", pend.keys, Key_Map, Key_Code, Key_Down);
  endtask

  // Steps start at cycle 0 of a frame; the previous step is checked at cycle 2 of this one.
  task automatic run_step(input step_t s);
    int waited;
    for (int f = 0; f < s.frames; f++) begin
      keys   = s.keys;
      waited = 0;
      if (f == 0 && pend_valid) begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        step_check();
        waited = 2;
      end
      if (f == 0 && s.pulse_off >= 0) begin
        sb_q.push_back('{s.exp_code, s.exp_map, 16 * (fidx + s.pulse_off) + 17});
      end
      repeat (16 - waited) @(posedge CLK);
      #1;
      fidx++;
    end
    pend       = s;
    pend_valid = 1'b1;
  endtask

  task automatic flush_check();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    step_check();
    pend_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {28'h0, Column_Scan_Sig}, 32'hE);
    check({tag, "_code"}, {28'h0, Key_Code}, 32'h0);
    check({tag, "_valid"}, {31'h0, Key_Valid}, 32'h0);
    check({tag, "_down"}, {31'h0, Key_Down}, 32'h0);
    check({tag, "_map"}, {16'h0, Key_Map}, 32'h0);
  endtask

  initial begin
    //           keys      frames off code   map       down
    steps[0] = '{16'h0000, 2, -1, 4'd0, 16'h0000, 1'b0};  // idle
    steps[1] = '{16'h0200, 4,  2, 4'd9, 16'h0200, 1'b1};  // hold key 9
    steps[2] = '{16'h0000, 3, -1, 4'd9, 16'h0000, 1'b0};  // release
    steps[3] = '{16'h0020, 2, -1, 4'd9, 16'h0000, 1'b0};  // key 5 bounce
    steps[4] = '{16'h0000, 3, -1, 4'd9, 16'h0000, 1'b0};
    steps[5] = '{16'h0200, 3,  2, 4'd9, 16'h0200, 1'b1};
    steps[6] = '{16'h4208, 3,  2, 4'd3, 16'h4208, 1'b1};  // add keys 3 and 14
    steps[7] = '{16'h0080, 2, -1, 4'd3, 16'h4208, 1'b1};  // key 7, two frames only

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    fidx = 0;

    for (int i = 0; i < 8; i++) run_step(steps[i]);
    flush_check();

    // Reset mid-debounce: partial count is lost, key 7 needs three fresh frames.
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge CLK);
    #1;
    RST  = 1'b0;
    fidx = 0;
    run_step('{16'h0080, 3, 2, 4'd7, 16'h0080, 1'b1});
    flush_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan_mod.md
Name: key_scan_mod

Overview:
- Matrix-keypad scanner for a 4x4 keypad; the input-side counterpart of the display scan path.
- Drives the keypad columns one at a time (active-low) and samples the four row lines.
- Debounces whole-matrix snapshots and reports each new key press as a one-cycle valid pulse with a 4-bit key code, plus a stable 16-bit key map.
- Sits between the board keypad pins and user logic, e.g. digit-entry logic that feeds the display encoders.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is held active (1 ms at 50 MHz). Legal range ≥ 4.
- DEB_SCANS, 10: number of consecutive identical full-matrix frames required before a map is accepted. Legal range ≥ 2.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Row_In  input  4  keypad row lines, active-low (pulled up externally), asynchronous to CLK.
- Column_Scan_Sig  output  4  column drive, active-low, exactly one bit low at any time.
- Key_Code  output  4  index of the most recently pressed key: col*4 + row.
- Key_Valid  output  1  one-cycle pulse: Key_Code updated for a new press.
- Key_Down  output  1  high while any key is held in the accepted map.
- Key_Map  output  16  accepted (debounced) key map; bit col*4+row set = key held.

Behaviour:
- Reset (RST high, asynchronous): clear all counters, synchronizers and frame registers.
  - Column_Scan_Sig = 4'b1110 (column 0 active).
  - Key_Code = 0, Key_Valid = 0, Key_Down = 0, Key_Map = 0.
  - Asserting reset mid-frame discards the partial frame and any partial debounce count. After release, scanning restarts at column 0, dwell count 0.
- Input synchronization: Row_In passes through a 2-flop synchronizer. The inverted synchronized value gives row_act[3:0] (1 = pressed).
- Scan counters:
  - dwell_cnt counts 0..SCAN_DIV-1; col_idx counts 0..3.
  - When dwell_cnt = SCAN_DIV-1: dwell_cnt wraps to 0 and col_idx increments, wrapping 3 -> 0.
  - Column_Scan_Sig = ~(1 << col_idx), registered. The column change occurs on the same edge col_idx changes.
- Sampling: on the cycle dwell_cnt = SCAN_DIV-1, row_act is written into frame bits [col_idx*4 +: 4].
  - The sync delay (2 cycles) is therefore always less than the settle time, since SCAN_DIV ≥ 4.
- Frame completion: the sample of column 3 completes a frame (every 4*SCAN_DIV cycles). On the following edge, the completed frame is compared with last_frame:
  - Equal: match_cnt increments, saturating at DEB_SCANS-1.
  - Different: match_cnt = 0 and last_frame = frame.
  - A frame is accepted when match_cnt reaches DEB_SCANS-1, i.e. DEB_SCANS identical consecutive frames.
- Acceptance (evaluated in the same comparison cycle):
  - If the accepted frame differs from Key_Map, Key_Map is loaded with it.
  - new_bits = accepted & ~old Key_Map. If new_bits ≠ 0:
    - Key_Code = index of the lowest set bit of new_bits.
    - Key_Valid = 1 for exactly one cycle, on the same edge Key_Map updates.
  - Releases (bits clearing) update Key_Map and Key_Down only; no Key_Valid, Key_Code held.
  - Once saturated, further identical frames cause no further updates or pulses. Auto-repeat is not supported.
- Key_Down = |Key_Map, registered together with Key_Map.
- Simultaneous new presses in one accepted frame produce one Key_Valid pulse, reporting the lowest index.
- Bounce or glitches lasting fewer than DEB_SCANS frames never change Key_Map.
- Latency: a clean press first present in frame N is accepted after frame N+DEB_SCANS-1 completes. Key_Valid follows 1 cycle after that frame's last sample.
- Ghosting from 3+ key combinations is not resolved; the map reports what the rows read.

Test Plan (SCAN_DIV=4, DEB_SCANS=3; frame = 16 cycles):
1. Reset then idle, rows all 1 -> Column_Scan_Sig sequence 1110, 1101, 1011, 0111, each held 4 cycles, repeating. Key_Valid stays 0, Key_Map = 0.
2. Hold key col 2 / row 1 (Row_In[1] low while Column_Scan_Sig[2] low) from frame 0 -> in frame 2's comparison cycle, one Key_Valid pulse with Key_Code = 9, Key_Map = 16'h0200, Key_Down = 1. No further pulses while held.
3. Release the key from scenario 2 -> after 3 clean frames, Key_Map = 0 and Key_Down = 0. No Key_Valid; Key_Code stays 9.
4. Press key 5 for 2 frames only (bounce), then release -> Key_Map never changes, no Key_Valid.
5. With key 9 held and accepted, add keys 3 and 14 together -> one pulse, Key_Code = 3, Key_Map = 16'h4208.
6. Assert RST mid-debounce (after 2 matching frames of key 7) -> all outputs return to reset values, Column_Scan_Sig = 1110. After release, key 7 needs 3 fresh frames before Key_Valid.
